// File: rtl/dram_axi_responder.sv
// dram_axi_responder
// Single-outstanding AXI-style responder backed by a DEPTH x 64-bit word store.
// Reads and writes each wait LAT cycles before the response is presented.
// A response becomes visible LAT cycles after the accepting handshake cycle.
// That accepting cycle is the AR handshake for reads and the W handshake for writes.
// The optional macro DRAM_ADDR_CHECK_EN enables address legality checking:
//   - a legal address has ADDR[16:11] == 6'b100000 and ADDR[2:0] == 0;
//   - an illegal access completes with SLVERR (2'b10);
//   - an illegal write is dropped, and an illegal read returns zero data.
module dram_axi_responder #(
    parameter int LAT   = 4,
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AR_VALID,
    input  logic [16:0] AR_ADDR,
    output logic        AR_READY,
    output logic        R_VALID,
    output logic [63:0] R_DATA,
    output logic [1:0]  R_RESP,
    input  logic        R_READY,
    input  logic        AW_VALID,
    input  logic [16:0] AW_ADDR,
    output logic        AW_READY,
    input  logic        W_VALID,
    input  logic [63:0] W_DATA,
    output logic        W_READY,
    output logic        B_VALID,
    output logic [1:0]  B_RESP,
    input  logic        B_READY
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_RESP = 3'd2;
    localparam logic [2:0] WR_DATA = 3'd3;
    localparam logic [2:0] WR_WAIT = 3'd4;
    localparam logic [2:0] WR_RESP = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]  stateReg;
    logic [3:0]  latCnt;
    logic [7:0]  addrReg;
    logic        addrOkReg;
    logic [63:0] rDataReg;
    logic [63:0] mem [DEPTH];

    logic        arFire;
    logic        awFire;
    logic        wFire;
    logic        arAddrOk;
    logic        awAddrOk;
    logic        latDone;
    logic [7:0]  readIdx;
    logic        readOk;

`ifdef DRAM_ADDR_CHECK_EN
    assign arAddrOk = (AR_ADDR[16:11] == 6'b100000) && (AR_ADDR[2:0] == 3'b000);
    assign awAddrOk = (AW_ADDR[16:11] == 6'b100000) && (AW_ADDR[2:0] == 3'b000);
`else
    // Upper and byte-offset address bits carry no meaning without checking.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{AR_ADDR[16:11], AR_ADDR[2:0], AW_ADDR[16:11], AW_ADDR[2:0]};
    assign arAddrOk = 1'b1;
    assign awAddrOk = 1'b1;
`endif

    // Handshakes: ready is only offered in IDLE, and the read wins ties.
    // Gating with rst_n keeps the ready outputs low while reset is held.
    assign arFire  = rst_n && (stateReg == IDLE) && AR_VALID;
    assign awFire  = rst_n && (stateReg == IDLE) && AW_VALID && !AR_VALID;
    assign wFire   = (stateReg == WR_DATA) && W_VALID;
    assign latDone = (latCnt == 4'(LAT - 1));

    // The read index comes from the bus on the accept cycle, otherwise from the latch.
    assign readIdx = (stateReg == IDLE) ? AR_ADDR[10:3] : addrReg;
    assign readOk  = (stateReg == IDLE) ? arAddrOk : addrOkReg;

    assign AR_READY = arFire;
    assign AW_READY = awFire;
    assign W_READY  = (stateReg == WR_DATA);
    assign R_VALID  = (stateReg == RD_RESP);
    assign R_DATA   = R_VALID ? rDataReg : 64'h0;
    assign R_RESP   = (R_VALID && !addrOkReg) ? RESP_SLVERR : RESP_OKAY;
    assign B_VALID  = (stateReg == WR_RESP);
    assign B_RESP   = (B_VALID && !addrOkReg) ? RESP_SLVERR : RESP_OKAY;

    // Transaction sequencing, latency counting and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            latCnt    <= 4'd0;
            addrReg   <= 8'd0;
            addrOkReg <= 1'b0;
            rDataReg  <= 64'h0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (arFire) begin
                        addrReg   <= AR_ADDR[10:3];
                        addrOkReg <= arAddrOk;
                        if (LAT == 1) begin
                            stateReg <= RD_RESP;
                            rDataReg <= readOk ? mem[readIdx] : 64'h0;
                        end else begin
                            stateReg <= RD_WAIT;
                            latCnt   <= 4'd1;
                        end
                    end else if (awFire) begin
                        addrReg   <= AW_ADDR[10:3];
                        addrOkReg <= awAddrOk;
                        stateReg  <= WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (latDone) begin
                        stateReg <= RD_RESP;
                        latCnt   <= 4'd0;
                        rDataReg <= readOk ? mem[readIdx] : 64'h0;
                    end else begin
                        latCnt <= latCnt + 4'd1;
                    end
                end
                RD_RESP: begin
                    if (R_READY) begin
                        stateReg <= IDLE;
                        rDataReg <= 64'h0;
                    end
                end
                WR_DATA: begin
                    if (W_VALID) begin
                        if (LAT == 1) begin
                            stateReg <= WR_RESP;
                        end else begin
                            stateReg <= WR_WAIT;
                            latCnt   <= 4'd1;
                        end
                    end
                end
                WR_WAIT: begin
                    if (latDone) begin
                        stateReg <= WR_RESP;
                        latCnt   <= 4'd0;
                    end else begin
                        latCnt <= latCnt + 4'd1;
                    end
                end
                WR_RESP: begin
                    if (B_READY) begin
                        stateReg <= IDLE;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                    latCnt   <= 4'd0;
                end
            endcase
        end
    end

    // Word store: cleared by reset, written only on a completed W handshake to a legal address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 64'h0;
            end
        end else if (wFire && addrOkReg) begin
            mem[addrReg] <= W_DATA;
        end
    end

endmodule

// File: tb/tb_dram_axi_responder.sv
// tb_dram_axi_responder
// Transaction-level model of the responder: a word array plus timing expressed
// as cycle offsets from each handshake. Each driver task publishes the expected
// output values for every cycle, and a single compare process checks them.
// Directed transactions pin the model with literal values.
// The random phase mixes reads, writes, simultaneous requests, back-pressure and resets.
// Build with DRAM_ADDR_CHECK_EN defined to exercise address checking.
module tb_dram_axi_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        AR_VALID;
    logic [16:0] AR_ADDR;
    logic        AR_READY;
    logic        R_VALID;
    logic [63:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        R_READY;
    logic        AW_VALID;
    logic [16:0] AW_ADDR;
    logic        AW_READY;
    logic        W_VALID;
    logic [63:0] W_DATA;
    logic        W_READY;
    logic        B_VALID;
    logic [1:0]  B_RESP;
    logic        B_READY;

    dram_axi_responder #(.LAT(LAT), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] modelMem [256];

    logic        expArReady, expAwReady, expWReady, expRValid, expBValid;
    logic [63:0] expRData;
    logic [1:0]  expRResp, expBResp;

    bit          awHold = 1'b0;
    logic [16:0] awHoldAddr = 17'h0;
    bit          releasePending = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit legal(input logic [16:0] a);
`ifdef DRAM_ADDR_CHECK_EN
        return (a[16:11] == 6'b100000) && (a[2:0] == 3'b000);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [16:0] randAddr();
        logic [7:0] idx;
        idx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
`ifdef DRAM_ADDR_CHECK_EN
        if ($urandom_range(0, 7) == 0) return 17'($urandom());
        return {6'b100000, idx, 3'b000};
`else
        return {6'($urandom()), idx, 3'($urandom())};
`endif
    endfunction

    // Every cycle, compare all outputs against the expectations of that cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("AR_READY", 64'(AR_READY), 64'(expArReady));
            chk("AW_READY", 64'(AW_READY), 64'(expAwReady));
            chk("W_READY",  64'(W_READY),  64'(expWReady));
            chk("R_VALID",  64'(R_VALID),  64'(expRValid));
            chk("R_DATA",   R_DATA,        expRData);
            chk("R_RESP",   64'(R_RESP),   64'(expRResp));
            chk("B_VALID",  64'(B_VALID),  64'(expBValid));
            chk("B_RESP",   64'(B_RESP),   64'(expBResp));
        end
    end

    // Safety net against a stuck run.
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

    // Open a new cycle: idle inputs with random don't-care values, all outputs expected low.
    task automatic startCycle();
        @(negedge clk);
        if (releasePending) begin
            rst_n = 1'b1;
            releasePending = 1'b0;
        end
        AR_VALID = 1'b0;
        AR_ADDR  = 17'($urandom());
        AW_VALID = awHold;
        AW_ADDR  = awHold ? awHoldAddr : 17'($urandom());
        W_VALID  = 1'b0;
        W_DATA   = {$urandom(), $urandom()};
        R_READY  = 1'($urandom());
        B_READY  = 1'($urandom());
        expArReady = 1'b0; expAwReady = 1'b0; expWReady = 1'b0;
        expRValid  = 1'b0; expBValid  = 1'b0;
        expRData   = 64'h0; expRResp = 2'b00; expBResp = 2'b00;
    endtask

    task automatic doRead(input logic [16:0] addr, input int rdelay,
                          output logic [63:0] gotData, output logic [1:0] gotResp);
        logic [63:0] want;
        logic [1:0]  wresp;
        want  = legal(addr) ? modelMem[addr[10:3]] : 64'h0;
        wresp = legal(addr) ? 2'b00 : 2'b10;
        startCycle();
        AR_VALID = 1'b1; AR_ADDR = addr; expArReady = 1'b1;
        for (int i = 1; i < LAT; i++) startCycle();
        for (int i = 0; i <= rdelay; i++) begin
            startCycle();
            R_READY = (i == rdelay);
            expRValid = 1'b1; expRData = want; expRResp = wresp;
        end
        #2;
        gotData = R_DATA;
        gotResp = R_RESP;
        $display("READ  addr=%05h wait=%0d data=%016h resp=%0d", addr, rdelay, gotData, gotResp);
    endtask

    task automatic doWrite(input logic [16:0] addr, input logic [63:0] data,
                           input int wdelay, input int bdelay, output logic [1:0] gotResp);
        startCycle();
        awHold = 1'b0;
        AW_VALID = 1'b1; AW_ADDR = addr; expAwReady = 1'b1;
        for (int i = 0; i <= wdelay; i++) begin
            startCycle();
            expWReady = 1'b1;
            W_VALID = (i == wdelay);
            if (i == wdelay) W_DATA = data;
        end
        if (legal(addr)) modelMem[addr[10:3]] = data;
        for (int i = 1; i < LAT; i++) startCycle();
        for (int i = 0; i <= bdelay; i++) begin
            startCycle();
            B_READY = (i == bdelay);
            expBValid = 1'b1; expBResp = legal(addr) ? 2'b00 : 2'b10;
        end
        #2;
        gotResp = B_RESP;
        $display("WRITE addr=%05h data=%016h wwait=%0d bwait=%0d resp=%0d", addr, data, wdelay, bdelay, gotResp);
    endtask

    // AR and AW raised together: the read is serviced and AW is held until the next IDLE cycle.
    task automatic doBoth(input logic [16:0] raddr, input logic [16:0] waddr, input logic [63:0] data,
                          output logic [63:0] gotData);
        logic [1:0] r;
        logic [1:0] b;
        awHold = 1'b1;
        awHoldAddr = waddr;
        doRead(raddr, $urandom_range(0, 2), gotData, r);
        doWrite(waddr, data, $urandom_range(0, 2), $urandom_range(0, 2), b);
    endtask

    // Hold reset over several cycles with busy inputs; release coincides with the next transaction.
    task automatic holdReset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            startCycle();
            rst_n = 1'b0;
            AR_VALID = 1'b1; AW_VALID = 1'b1; W_VALID = 1'b1;
            R_READY = 1'b1; B_READY = 1'b1;
        end
        awHold = 1'b0;
        for (int i = 0; i < 256; i++) modelMem[i] = 64'h0;
        releasePending = 1'b1;
    endtask

    task automatic doResetMidWrite(input logic [16:0] addr, input int wcycles);
        startCycle();
        AW_VALID = 1'b1; AW_ADDR = addr; expAwReady = 1'b1;
        for (int i = 0; i < wcycles; i++) begin
            startCycle();
            expWReady = 1'b1;
        end
        holdReset(3);
        $display("RESET during write data phase addr=%05h after %0d cycles", addr, wcycles);
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  r;
        logic [1:0]  b;
        int kind;

        for (int i = 0; i < 256; i++) modelMem[i] = 64'h0;
        rst_n = 1'b0;
        AR_VALID = 1'b0; AR_ADDR = 17'h0; AW_VALID = 1'b0; AW_ADDR = 17'h0;
        W_VALID = 1'b0; W_DATA = 64'h0; R_READY = 1'b0; B_READY = 1'b0;
        expArReady = 1'b0; expAwReady = 1'b0; expWReady = 1'b0;
        expRValid = 1'b0; expBValid = 1'b0;
        expRData = 64'h0; expRResp = 2'b00; expBResp = 2'b00;

        holdReset(3);

        // Read straight after reset release.
        doRead(17'h10008, 0, d, r);
        chk("reset_read_data", d, 64'h0);
        chk("reset_read_resp", 64'(r), 64'h0);

        // Write then read back.
        doWrite(17'h107F8, 64'hDEADBEEF_01234567, 0, 0, b);
        chk("write_bresp", 64'(b), 64'h0);
        doRead(17'h107F8, 0, d, r);
        chk("readback_data", d, 64'hDEADBEEF_01234567);

        // Long R back-pressure; stability is checked every cycle.
        doRead(17'h107F8, 10, d, r);
        chk("backpressure_data", d, 64'hDEADBEEF_01234567);

        // Simultaneous AR and AW.
        doBoth(17'h107F8, 17'h10010, 64'hA5A5_5A5A_0F0F_F0F0, d);
        chk("both_read_data", d, 64'hDEADBEEF_01234567);
        doRead(17'h10010, 1, d, r);
        chk("both_write_data", d, 64'hA5A5_5A5A_0F0F_F0F0);

        // Reset during the W wait, then read back.
        doResetMidWrite(17'h10018, 2);
        doRead(17'h10018, 0, d, r);
        chk("abort_write_word", d, 64'h0);
        doRead(17'h107F8, 0, d, r);
        chk("reset_cleared_word", d, 64'h0);

        // Address outside the legal window (index 2).
        doWrite(17'h00010, 64'h5555_6666_7777_8888, 1, 1, b);
        doRead(17'h00010, 0, d, r);
`ifdef DRAM_ADDR_CHECK_EN
        chk("illegal_bresp", 64'(b), 64'h2);
        chk("illegal_rresp", 64'(r), 64'h2);
        chk("illegal_rdata", d, 64'h0);
        doRead(17'h10010, 0, d, r);
        chk("illegal_word_untouched", d, 64'h0);
`else
        chk("alias_bresp", 64'(b), 64'h0);
        chk("alias_rresp", 64'(r), 64'h0);
        chk("alias_rdata", d, 64'h5555_6666_7777_8888);
        doRead(17'h10010, 0, d, r);
        chk("alias_word", d, 64'h5555_6666_7777_8888);
`endif

        // Randomized traffic against the model.
        for (int t = 0; t < 300; t++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) startCycle();
            kind = $urandom_range(0, 9);
            if (t % 100 == 99) begin
                doResetMidWrite(randAddr(), $urandom_range(0, 3));
            end else if (kind < 4) begin
                doRead(randAddr(), $urandom_range(0, 3), d, r);
            end else if (kind < 8) begin
                doWrite(randAddr(), {$urandom(), $urandom()}, $urandom_range(0, 3), $urandom_range(0, 3), b);
            end else begin
                doBoth(randAddr(), randAddr(), {$urandom(), $urandom()}, d);
            end
        end
        startCycle();
        startCycle();
        @(negedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
